// File: rtl/uart_pkg.sv
// Shared constants and controller state encoding for the UART receive path.
// Imported by the receive controller and reusable by the transmit side.
package uart_pkg;

  localparam int OVERSAMPLE  = 16;
  localparam int ERR_CNT_MAX = 255;

  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_ARM      = 2'd1,
    ST_ACTIVE   = 2'd2,
    ST_STOPPING = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with push/pop, full/empty and occupancy count.
// A push while full is accepted only when a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt_q;
  logic             wr_ok;
  logic             rd_ok;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign rd_ok = pop & ~empty;
  assign wr_ok = push & (~full | pop);
  // Head is forced to zero when empty so the output is defined out of reset.
  assign dout  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/uart8_rx_controller.sv
// Sequences an 8-bit UART receiver: enable/arm/stop control, done/err edge capture,
// byte FIFO behind a valid/ready host port, error/overrun status and end-of-burst detect.
module uart8_rx_controller
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int IDLE_BAUDS   = 3,
  parameter int STOP_TIMEOUT = 160
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          err_clear,
  output logic                          rx_en,
  input  logic                          rx_busy,
  input  logic                          rx_done,
  input  logic                          rx_err,
  input  logic [7:0]                    rx_data,
  output logic [7:0]                    m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  output logic [7:0]                    frame_err_count,
  output logic                          line_idle,
  output logic                          active,
  output ctrl_state_e                   state_dbg
);

  // Host handshake: a byte transfers on a cycle where m_valid and m_ready are both high;
  // m_valid never depends on m_ready, and m_data is stable while m_valid waits for m_ready.

  localparam int IDLE_LIM = IDLE_BAUDS * OVERSAMPLE - 1;
  localparam int IW       = $clog2(IDLE_LIM + 1) + 1;
  localparam int SW       = $clog2(STOP_TIMEOUT + 1);

  ctrl_state_e   state_q, state_d;
  logic [3:0]    arm_cnt;
  logic [SW-1:0] stop_cnt;
  logic [IW-1:0] idle_cnt;
  logic          got_byte;
  logic          done_q, err_q;
  logic          done_ev, err_ev;
  logic          capture, capture_next;
  logic          push, pop, fifo_full, fifo_empty;

  assign done_ev      = rx_done & ~done_q;
  assign err_ev       = rx_err & ~err_q;
  assign capture      = (state_q == ST_ACTIVE) || (state_q == ST_STOPPING);
  assign capture_next = (state_d == ST_ACTIVE) || (state_d == ST_STOPPING);
  assign push         = capture & done_ev;
  assign pop          = m_ready & m_valid;
  assign m_valid      = ~fifo_empty;
  assign state_dbg    = state_q;

  always_comb begin
    state_d   = state_q;
    rx_en     = 1'b0;
    active    = 1'b0;
    line_idle = 1'b0;
    case (state_q)
      ST_OFF: begin
        if (enable) state_d = ST_ARM;
      end
      ST_ARM: begin
        rx_en = 1'b1;
        if (!enable) state_d = ST_OFF;
        else if (arm_cnt == 4'(OVERSAMPLE - 1)) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        rx_en  = 1'b1;
        active = 1'b1;
        if (!enable) state_d = ST_STOPPING;
      end
      ST_STOPPING: begin
        rx_en = 1'b1;
        if (enable) state_d = ST_ACTIVE;
        else if ((!rx_busy && !rx_done) || stop_cnt == SW'(STOP_TIMEOUT - 1)) state_d = ST_OFF;
      end
      default: state_d = ST_OFF;
    endcase
    if (capture && got_byte && idle_cnt == IW'(IDLE_LIM)) line_idle = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_OFF;
      arm_cnt  <= '0;
      stop_cnt <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      done_q   <= rx_done;
      err_q    <= rx_err;
      arm_cnt  <= (state_q == ST_ARM) ? arm_cnt + 1'b1 : '0;
      stop_cnt <= (state_q == ST_STOPPING && state_d == ST_STOPPING) ? stop_cnt + 1'b1 : '0;
    end
  end

  // Set on a dropped byte wins over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun         <= 1'b0;
      frame_err_count <= '0;
    end else begin
      if (push && fifo_full && !pop) overrun <= 1'b1;
      else if (err_clear)            overrun <= 1'b0;

      if (err_clear)              frame_err_count <= (capture && err_ev) ? 8'd1 : 8'd0;
      else if (capture && err_ev &&
               frame_err_count != 8'(ERR_CNT_MAX)) frame_err_count <= frame_err_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
      got_byte <= 1'b0;
    end else if (!capture_next) begin
      idle_cnt <= '0;
      got_byte <= 1'b0;
    end else begin
      if (rx_busy || done_ev)  idle_cnt <= '0;
      else if (idle_cnt != '1) idle_cnt <= idle_cnt + 1'b1;

      if (push)           got_byte <= 1'b1;
      else if (line_idle) got_byte <= 1'b0;
    end
  end

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (rx_data),
    .pop   (pop),
    .dout  (m_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_uart8_rx_controller.sv
// Directed bench for uart8_rx_controller: startup, capture, overrun, error counting,
// graceful/timeout stop and asynchronous reset.
module tb_uart8_rx_controller;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        err_clear = 1'b0;
  logic        rx_en;
  logic        rx_busy = 1'b0;
  logic        rx_done = 1'b0;
  logic        rx_err = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [3:0]  fifo_count;
  logic        overrun;
  logic [7:0]  frame_err_count;
  logic        line_idle;
  logic        active;
  ctrl_state_e state_dbg;

  int tests_run = 0;
  int tests_failed = 0;

  uart8_rx_controller #(
    .FIFO_DEPTH   (8),
    .IDLE_BAUDS   (3),
    .STOP_TIMEOUT (160)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .err_clear       (err_clear),
    .rx_en           (rx_en),
    .rx_busy         (rx_busy),
    .rx_done         (rx_done),
    .rx_err          (rx_err),
    .rx_data         (rx_data),
    .m_data          (m_data),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .fifo_count      (fifo_count),
    .overrun         (overrun),
    .frame_err_count (frame_err_count),
    .line_idle       (line_idle),
    .active          (active),
    .state_dbg       (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; err_clear = 1'b0; rx_busy = 1'b0;
    rx_done = 1'b0; rx_err = 1'b0; rx_data = 8'h00; m_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic go_active();
    enable = 1'b1;
    repeat (17) tick();
  endtask

  // One full 16-tick done pulse followed by one low tick.
  task automatic send_done(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    repeat (16) tick();
    rx_done = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({rx_en, m_valid, overrun, line_idle, active} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 00000", {rx_en, m_valid, overrun, line_idle, active});
    end
    tests_run++;
    if (fifo_count !== 4'd0 || frame_err_count !== 8'd0 || m_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_counts: got count=%0d errs=%0d data=%h expected 0/0/00", fifo_count, frame_err_count, m_data);
    end
    tests_run++;
    if (state_dbg !== ST_OFF) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d expected %0d", state_dbg, ST_OFF);
    end
  endtask

  task automatic test_single_byte();
    int pulses = 0;
    int pulse_at = -1;
    enable = 1'b1;
    tick();
    tests_run++;
    if (rx_en !== 1'b1 || active !== 1'b0) begin
      tests_failed++;
      $display("FAIL arm_entry: got rx_en=%b active=%b expected 1/0", rx_en, active);
    end
    repeat (15) tick();
    tests_run++;
    if (active !== 1'b0) begin
      tests_failed++;
      $display("FAIL arm_early: got active=%b expected 0", active);
    end
    tick();
    tests_run++;
    if (active !== 1'b1) begin
      tests_failed++;
      $display("FAIL arm_done: got active=%b expected 1", active);
    end
    rx_data = 8'hA5;
    rx_done = 1'b1;
    tick();
    tests_run++;
    if (m_valid !== 1'b1 || m_data !== 8'hA5 || fifo_count !== 4'd1) begin
      tests_failed++;
      $display("FAIL first_push: got valid=%b data=%h count=%0d expected 1/a5/1", m_valid, m_data, fifo_count);
    end
    repeat (15) tick();
    rx_done = 1'b0;
    tests_run++;
    if (fifo_count !== 4'd1) begin
      tests_failed++;
      $display("FAIL single_push: got count=%0d expected 1", fifo_count);
    end
    // idle_cnt equals k after the k-th edge past the done edge; the pulse sits at k=47.
    for (int k = 16; k <= 120; k++) begin
      tick();
      if (line_idle === 1'b1) begin
        pulses++;
        pulse_at = k;
      end
    end
    tests_run++;
    if (pulses != 1 || pulse_at != 47) begin
      tests_failed++;
      $display("FAIL line_idle: got %0d pulses at %0d expected 1 at 47", pulses, pulse_at);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    tests_run++;
    if (m_valid !== 1'b0 || fifo_count !== 4'd0) begin
      tests_failed++;
      $display("FAIL single_pop: got valid=%b count=%0d expected 0/0", m_valid, fifo_count);
    end
  endtask

  task automatic test_overrun();
    m_ready = 1'b0;
    for (int i = 1; i <= 9; i++) send_done(8'(i));
    tests_run++;
    if (fifo_count !== 4'd8 || overrun !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun_fill: got count=%0d overrun=%b expected 8/1", fifo_count, overrun);
    end
    for (int i = 1; i <= 8; i++) begin
      tests_run++;
      if (m_valid !== 1'b1 || m_data !== 8'(i)) begin
        tests_failed++;
        $display("FAIL drain_%0d: got valid=%b data=%h expected 1/%h", i, m_valid, m_data, 8'(i));
      end
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
    end
    tests_run++;
    if (m_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain_empty: got valid=%b expected 0", m_valid);
    end
    // Pop while empty must not disturb the count.
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    tests_run++;
    if (overrun !== 1'b0 || fifo_count !== 4'd0) begin
      tests_failed++;
      $display("FAIL overrun_clear: got overrun=%b count=%0d expected 0/0", overrun, fifo_count);
    end
    for (int i = 0; i < 8; i++) send_done(8'h10 + 8'(i));
    rx_data = 8'h18;
    rx_done = 1'b1;
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    tests_run++;
    if (fifo_count !== 4'd8 || overrun !== 1'b0 || m_data !== 8'h11) begin
      tests_failed++;
      $display("FAIL full_push_pop: got count=%0d overrun=%b head=%h expected 8/0/11", fifo_count, overrun, m_data);
    end
    repeat (15) tick();
    rx_done = 1'b0;
    tick();
    for (int i = 1; i <= 8; i++) begin
      tests_run++;
      if (m_data !== 8'h10 + 8'(i)) begin
        tests_failed++;
        $display("FAIL wrap_drain_%0d: got %h expected %h", i, m_data, 8'h10 + 8'(i));
      end
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
    end
  endtask

  task automatic test_err_count();
    for (int i = 0; i < 3; i++) begin
      rx_err = 1'b1; tick();
      rx_err = 1'b0; tick();
    end
    tests_run++;
    if (frame_err_count !== 8'd3) begin
      tests_failed++;
      $display("FAIL err_three: got %0d expected 3", frame_err_count);
    end
    // A held err level counts once.
    rx_err = 1'b1; repeat (5) tick();
    rx_err = 1'b0; tick();
    tests_run++;
    if (frame_err_count !== 8'd4) begin
      tests_failed++;
      $display("FAIL err_level: got %0d expected 4", frame_err_count);
    end
    for (int i = 0; i < 300; i++) begin
      rx_err = 1'b1; tick();
      rx_err = 1'b0; tick();
    end
    tests_run++;
    if (frame_err_count !== 8'd255) begin
      tests_failed++;
      $display("FAIL err_saturate: got %0d expected 255", frame_err_count);
    end
    rx_err = 1'b1;
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    rx_err = 1'b0;
    tests_run++;
    if (frame_err_count !== 8'd1) begin
      tests_failed++;
      $display("FAIL err_clear_edge: got %0d expected 1", frame_err_count);
    end
    tick();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    tests_run++;
    if (frame_err_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL err_clear: got %0d expected 0", frame_err_count);
    end
  endtask

  task automatic test_stop();
    rx_busy = 1'b1;
    enable = 1'b0;
    tick();
    tests_run++;
    if (state_dbg !== ST_STOPPING || rx_en !== 1'b1 || active !== 1'b0) begin
      tests_failed++;
      $display("FAIL stop_enter: got state=%0d rx_en=%b active=%b expected %0d/1/0", state_dbg, rx_en, active, ST_STOPPING);
    end
    rx_data = 8'h3C;
    rx_done = 1'b1;
    tick();
    tests_run++;
    if (fifo_count !== 4'd1 || m_data !== 8'h3C) begin
      tests_failed++;
      $display("FAIL stop_push: got count=%0d data=%h expected 1/3c", fifo_count, m_data);
    end
    repeat (15) tick();
    rx_done = 1'b0;
    rx_busy = 1'b0;
    tick();
    tests_run++;
    if (state_dbg !== ST_OFF || rx_en !== 1'b0 || m_valid !== 1'b1 || m_data !== 8'h3C) begin
      tests_failed++;
      $display("FAIL stop_exit: got state=%0d rx_en=%b valid=%b data=%h expected %0d/0/1/3c", state_dbg, rx_en, m_valid, m_data, ST_OFF);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    go_active();
    rx_busy = 1'b1;
    enable = 1'b0;
    tick();
    repeat (159) tick();
    tests_run++;
    if (rx_en !== 1'b1 || state_dbg !== ST_STOPPING) begin
      tests_failed++;
      $display("FAIL timeout_early: got rx_en=%b state=%0d expected 1/%0d", rx_en, state_dbg, ST_STOPPING);
    end
    tick();
    tests_run++;
    if (rx_en !== 1'b0 || state_dbg !== ST_OFF) begin
      tests_failed++;
      $display("FAIL timeout_exit: got rx_en=%b state=%0d expected 0/%0d", rx_en, state_dbg, ST_OFF);
    end
    rx_busy = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    go_active();
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_done(8'hC0 + 8'(i));
    rx_err = 1'b1; tick();
    rx_err = 1'b0; tick();
    tests_run++;
    if (fifo_count !== 4'd3 || frame_err_count !== 8'd1) begin
      tests_failed++;
      $display("FAIL pre_reset: got count=%0d errs=%0d expected 3/1", fifo_count, frame_err_count);
    end
    rx_busy = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (rx_en !== 1'b0 || m_valid !== 1'b0 || fifo_count !== 4'd0 ||
        overrun !== 1'b0 || frame_err_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL async_reset: got rx_en=%b valid=%b count=%0d overrun=%b errs=%0d expected all 0",
               rx_en, m_valid, fifo_count, overrun, frame_err_count);
    end
    rx_busy = 1'b0;
    enable = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_overrun();
    test_err_count();
    test_stop();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
